// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
//   Bundles the event inputs and PC/imem control outputs of the fetch
//   sequencer. The sequencer connects through the 'slave' modport; the
//   hazard/branch side (or a testbench) uses 'master'.
//
//   Signals
//     start       master->slave  one-cycle pulse, leaves IDLE
//     hazard      master->slave  load-use hazard in decode (level)
//     redirect    master->slave  taken branch/jump resolved in EX (pulse)
//     target      master->slave  absolute redirect word address
//     halt_seen   master->slave  HALT opcode present in decode
//     fetch_en    slave->master  PC advances at this edge
//     jump        slave->master  PC loads 'next' instead of PC+1
//     next        slave->master  redirect address (0 when jump=0)
//     nop_insert  slave->master  replace fetched instruction with a NOP
//     hlt         slave->master  processor stopped
//     state       slave->master  current sequencer state
//     bubble_cnt  slave->master  saturating count of counted NOP cycles
//
//   Configuration macro SINGLE_STEP_EN adds:
//     step        master->slave  advance one instruction (pulse)
//     step_ack    slave->master  high during the single stepped RUN cycle
// -----------------------------------------------------------------------------
interface fetch_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             hazard;
  logic             redirect;
  logic [31:0]      target;
  logic             halt_seen;
  logic             fetch_en;
  logic             jump;
  logic [31:0]      next;
  logic             nop_insert;
  logic             hlt;
  logic [2:0]       state;
  logic [CNT_W-1:0] bubble_cnt;
`ifdef SINGLE_STEP_EN
  logic             step;
  logic             step_ack;

  modport master (
    output start, hazard, redirect, target, halt_seen, step,
    input  fetch_en, jump, next, nop_insert, hlt, state, bubble_cnt, step_ack
  );

  modport slave (
    input  start, hazard, redirect, target, halt_seen, step,
    output fetch_en, jump, next, nop_insert, hlt, state, bubble_cnt, step_ack
  );
`else
  modport master (
    output start, hazard, redirect, target, halt_seen,
    input  fetch_en, jump, next, nop_insert, hlt, state, bubble_cnt
  );

  modport slave (
    input  start, hazard, redirect, target, halt_seen,
    output fetch_en, jump, next, nop_insert, hlt, state, bubble_cnt
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Front-end sequencer for the PC / instruction-memory block. Arbitrates
//   EX redirects, HALT reaching decode and decode load-use hazards, and
//   drives PC advance, absolute redirects, NOP injection and halt.
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  synchronous reset, active-high
//     bus   fetch_if.slave  event inputs and PC/imem control outputs
//
//   Parameters
//     STALL_DEPTH  minimum NOP cycles held in STALL per hazard (>=1)
//     FLUSH_DEPTH  NOP cycles after a redirect, PC held at target (>=1)
//     DRAIN_DEPTH  NOP cycles after HALT before hlt asserts (>=1)
//     CNT_W        width of bubble_cnt (must match the interface)
//
//   Configuration macro SINGLE_STEP_EN: start enters STEP_WAIT, each step
//   pulse grants one RUN cycle (step_ack=1), and STALL/FLUSH/DRAIN return
//   to STEP_WAIT instead of RUN.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int STALL_DEPTH = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int DRAIN_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STALL     = 3'd2,
    FLUSH     = 3'd3,
    DRAIN     = 3'd4,
    HALTED    = 3'd5,
    STEP_WAIT = 3'd6
  } state_t;

  localparam int MAX_SF = (STALL_DEPTH > FLUSH_DEPTH) ? STALL_DEPTH : FLUSH_DEPTH;
  localparam int MAX_D  = (MAX_SF > DRAIN_DEPTH) ? MAX_SF : DRAIN_DEPTH;
  localparam int CW     = $clog2(MAX_D) + 1;

  localparam logic [CW-1:0] STALL_LD = CW'(STALL_DEPTH - 1);
  localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_DEPTH - 1);

  // Where execution resumes after start or after a bubble sequence ends.
`ifdef SINGLE_STEP_EN
  localparam state_t RESUME = STEP_WAIT;
`else
  localparam state_t RESUME = RUN;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_dec;
  logic [CNT_W-1:0] bubble_q;

  logic        fetch_en, jump, nop_insert, hlt, count_bubble;
  logic [31:0] next_addr;
`ifdef SINGLE_STEP_EN
  logic        step_ack;
`endif

  // ---------------------------------------------------------------------------
  // State register, bubble counter and NOP countdown
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bubble_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Saturate rather than wrap so a long run never reads as few bubbles.
      if (count_bubble && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A redirect from any bubble state is a wrong-path event:
  // it cancels the pending stall/drain and restarts the flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults ahead of the case keep every path assigned, so no
    // latches are inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    case (state_q)
      IDLE: if (bus.start) state_d = RESUME;
      RUN: begin
        if (bus.redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (bus.halt_seen) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LD;
        end else if (bus.hazard) begin
          state_d = STALL;
          cnt_d   = STALL_LD;
        end else begin
          state_d = RESUME;
        end
      end
      STALL: begin
        if (bus.redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if ((cnt_q == '0) && !bus.hazard) begin
          state_d = RESUME;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      FLUSH: begin
        if (bus.redirect) begin
          cnt_d = FLUSH_LD;
        end else if (cnt_q == '0) begin
          state_d = RESUME;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      HALTED: ;
`ifdef SINGLE_STEP_EN
      STEP_WAIT: begin
        if (bus.redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LD;
        end else if (bus.step) begin
          state_d = RUN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Everything except RUN without a bubble entry injects a NOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_en     = 1'b0;
    jump         = 1'b0;
    next_addr    = '0;
    nop_insert   = 1'b1;
    hlt          = 1'b0;
    count_bubble = 1'b0;
`ifdef SINGLE_STEP_EN
    step_ack     = 1'b0;
`endif
    case (state_q)
      IDLE:   hlt = 1'b1;
      HALTED: hlt = 1'b1;
      RUN: begin
`ifdef SINGLE_STEP_EN
        step_ack = 1'b1;
`endif
        if (bus.redirect) begin
          fetch_en   = 1'b1;
          jump       = 1'b1;
          next_addr  = bus.target;
          nop_insert = 1'b0;
        end else if (bus.halt_seen || bus.hazard) begin
          // Entry cycle of a drain/stall is already a bubble.
          count_bubble = 1'b1;
        end else begin
          fetch_en   = 1'b1;
          nop_insert = 1'b0;
        end
      end
      STALL, FLUSH, DRAIN: begin
        count_bubble = 1'b1;
        if (bus.redirect) begin
          fetch_en  = 1'b1;
          jump      = 1'b1;
          next_addr = bus.target;
        end
      end
`ifdef SINGLE_STEP_EN
      STEP_WAIT: begin
        if (bus.redirect) begin
          fetch_en  = 1'b1;
          jump      = 1'b1;
          next_addr = bus.target;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.fetch_en   = fetch_en;
  assign bus.jump       = jump;
  assign bus.next       = next_addr;
  assign bus.nop_insert = nop_insert;
  assign bus.hlt        = hlt;
  assign bus.state      = state_q;
  assign bus.bubble_cnt = bubble_q;
`ifdef SINGLE_STEP_EN
  assign bus.step_ack   = step_ack;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer (default build). Two DUTs share
//   the same stimulus: one with a 16-bit bubble counter and one with a 3-bit
//   counter so saturation is reachable. Phases: reset, a table of
//   hand-derived vectors, hand-written multi-cycle sequences, then random
//   stimulus compared against a behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int STALL_DEPTH = 2;
  localparam int FLUSH_DEPTH = 2;
  localparam int DRAIN_DEPTH = 4;
  localparam int CNT_W       = 16;
  localparam int SAT_W       = 3;
  localparam int SAT_MAX     = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  fetch_if #(.CNT_W(CNT_W)) bus ();
  fetch_if #(.CNT_W(SAT_W)) bus_s ();

  fetch_sequencer #(
    .STALL_DEPTH(STALL_DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH),
    .DRAIN_DEPTH(DRAIN_DEPTH), .CNT_W(CNT_W)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  fetch_sequencer #(
    .STALL_DEPTH(STALL_DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH),
    .DRAIN_DEPTH(DRAIN_DEPTH), .CNT_W(SAT_W)
  ) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        hazard;
    logic        redirect;
    logic        halt;
    logic [31:0] target;
  } in_t;

  typedef struct {
    in_t         in;
    int          state;
    logic        fetch_en;
    logic        jump;
    logic [31:0] next;
    logic        nop;
    logic        hlt;
    int          bubble;
  } vec_t;

  int  n_checks = 0;
  int  n_errors = 0;
  in_t cur;

  function automatic in_t mkin(logic r, logic s, logic hz, logic rd,
                               logic [31:0] t, logic h);
    in_t v;
    v.rst = r; v.start = s; v.hazard = hz; v.redirect = rd; v.target = t; v.halt = h;
    return v;
  endfunction

  function automatic vec_t mkv(in_t v, int st, logic fe, logic j, logic [31:0] nx,
                               logic nop, logic hl, int b);
    vec_t r;
    r.in = v; r.state = st; r.fetch_en = fe; r.jump = j; r.next = nx;
    r.nop = nop; r.hlt = hl; r.bubble = b;
    return r;
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input in_t v);
    cur            = v;
    rst            = v.rst;
    bus.start      = v.start;     bus_s.start     = v.start;
    bus.hazard     = v.hazard;    bus_s.hazard    = v.hazard;
    bus.redirect   = v.redirect;  bus_s.redirect  = v.redirect;
    bus.target     = v.target;    bus_s.target    = v.target;
    bus.halt_seen  = v.halt;      bus_s.halt_seen = v.halt;
  endtask

  // Drive at the falling edge, then let combinational outputs settle.
  task automatic tick(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Phases use the externally visible state numbers;
  // 'm_left' is the number of further mandatory bubble cycles.
  // ---------------------------------------------------------------------------
  int m_ph   = 0;
  int m_left = 0;
  int m_bub  = 0;

  function automatic bit is_busy(int ph);
    return (ph == 2) || (ph == 3) || (ph == 4);
  endfunction

  function automatic bit wrong_path(in_t v, int ph);
    return v.redirect && ((ph == 1) || is_busy(ph));
  endfunction

  function automatic bit bubble_entry(in_t v, int ph);
    return (ph == 1) && !v.redirect && (v.hazard || v.halt);
  endfunction

  always @(posedge clk) begin
    if (cur.rst) begin
      m_ph   <= 0;
      m_left <= 0;
      m_bub  <= 0;
    end else begin
      if (is_busy(m_ph) || bubble_entry(cur, m_ph)) m_bub <= m_bub + 1;
      if (wrong_path(cur, m_ph)) begin
        m_ph   <= 3;
        m_left <= FLUSH_DEPTH - 1;
      end else begin
        case (m_ph)
          0: if (cur.start) m_ph <= 1;
          1: begin
            if (cur.halt) begin
              m_ph <= 4; m_left <= DRAIN_DEPTH - 1;
            end else if (cur.hazard) begin
              m_ph <= 2; m_left <= STALL_DEPTH - 1;
            end
          end
          2: begin
            if (m_left == 0 && !cur.hazard) m_ph <= 1;
            else m_left <= max_i(m_left - 1, 0);
          end
          3: begin
            if (m_left == 0) m_ph <= 1;
            else m_left <= m_left - 1;
          end
          4: begin
            if (m_left == 0) m_ph <= 5;
            else m_left <= m_left - 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic compare_model(input string tag);
    bit wp, fetching;
    wp       = wrong_path(cur, m_ph);
    fetching = (m_ph == 1) && !bubble_entry(cur, m_ph);
    check({tag, ".state"},      32'(bus.state),          32'(m_ph));
    check({tag, ".fetch_en"},   32'(bus.fetch_en),       32'(fetching || wp));
    check({tag, ".jump"},       32'(bus.jump),           32'(wp));
    check({tag, ".next"},       bus.next,                wp ? cur.target : 32'd0);
    check({tag, ".nop_insert"}, 32'(bus.nop_insert),     32'(!fetching));
    check({tag, ".hlt"},        32'(bus.hlt),            32'((m_ph == 0) || (m_ph == 5)));
    check({tag, ".bubble"},     32'(bus.bubble_cnt),     32'(m_bub));
    check({tag, ".bubble_sat"}, 32'(bus_s.bubble_cnt),   32'(min_i(m_bub, SAT_MAX)));
  endtask

  // Global watchdog: the bench must always end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[18];
    in_t  idle;
    int   n;
    bit   reached;

    idle = mkin(0, 0, 0, 0, 32'd0, 0);

    // Table: {inputs}, state, fetch_en, jump, next, nop, hlt, bubble_cnt
    vecs[0]  = mkv(idle,                            0, 0, 0, 32'd0,  1, 1, 0);
    vecs[1]  = mkv(mkin(0, 0, 1, 1, 32'd9, 1),      0, 0, 0, 32'd0,  1, 1, 0);
    vecs[2]  = mkv(mkin(0, 1, 0, 0, 32'd0, 0),      0, 0, 0, 32'd0,  1, 1, 0);
    vecs[3]  = mkv(idle,                            1, 1, 0, 32'd0,  0, 0, 0);
    vecs[4]  = mkv(mkin(0, 0, 1, 0, 32'd0, 0),      1, 0, 0, 32'd0,  1, 0, 0);
    vecs[5]  = mkv(idle,                            2, 0, 0, 32'd0,  1, 0, 1);
    vecs[6]  = mkv(idle,                            2, 0, 0, 32'd0,  1, 0, 2);
    vecs[7]  = mkv(idle,                            1, 1, 0, 32'd0,  0, 0, 3);
    vecs[8]  = mkv(mkin(0, 0, 1, 1, 32'd23, 0),     1, 1, 1, 32'd23, 0, 0, 3);
    vecs[9]  = mkv(idle,                            3, 0, 0, 32'd0,  1, 0, 3);
    vecs[10] = mkv(idle,                            3, 0, 0, 32'd0,  1, 0, 4);
    vecs[11] = mkv(idle,                            1, 1, 0, 32'd0,  0, 0, 5);
    vecs[12] = mkv(mkin(0, 0, 0, 0, 32'd0, 1),      1, 0, 0, 32'd0,  1, 0, 5);
    vecs[13] = mkv(idle,                            4, 0, 0, 32'd0,  1, 0, 6);
    vecs[14] = mkv(mkin(0, 0, 0, 1, 32'd5, 0),      4, 1, 1, 32'd5,  1, 0, 7);
    vecs[15] = mkv(idle,                            3, 0, 0, 32'd0,  1, 0, 8);
    vecs[16] = mkv(mkin(1, 0, 0, 0, 32'd0, 0),      3, 0, 0, 32'd0,  1, 0, 9);
    vecs[17] = mkv(idle,                            0, 0, 0, 32'd0,  1, 1, 0);

    // Reset from power-up.
    drive(mkin(1, 0, 0, 0, 32'd0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].in);
      check($sformatf("vec%0d.state", i),      32'(bus.state),        32'(vecs[i].state));
      check($sformatf("vec%0d.fetch_en", i),   32'(bus.fetch_en),     32'(vecs[i].fetch_en));
      check($sformatf("vec%0d.jump", i),       32'(bus.jump),         32'(vecs[i].jump));
      check($sformatf("vec%0d.next", i),       bus.next,              vecs[i].next);
      check($sformatf("vec%0d.nop_insert", i), 32'(bus.nop_insert),   32'(vecs[i].nop));
      check($sformatf("vec%0d.hlt", i),        32'(bus.hlt),          32'(vecs[i].hlt));
      check($sformatf("vec%0d.bubble", i),     32'(bus.bubble_cnt),   32'(vecs[i].bubble));
      check($sformatf("vec%0d.bubble_sat", i), 32'(bus_s.bubble_cnt), 32'(min_i(vecs[i].bubble, SAT_MAX)));
    end

    // Start, then five plain RUN cycles fetching with no bubbles.
    tick(mkin(0, 1, 0, 0, 32'd0, 0));
    for (int c = 0; c < 5; c++) begin
      tick(idle);
      check($sformatf("run%0d.fetch_en", c), 32'(bus.fetch_en), 32'd1);
    end
    check("run.bubble", 32'(bus.bubble_cnt), 32'd0);

    // Hazard held for 1 and 5 cycles: entry cycle plus max(depth, hold) stall cycles.
    for (int k = 0; k < 2; k++) begin
      int hold;
      hold = (k == 0) ? 1 : 5;
      n = 0;
      reached = 1'b0;
      for (int c = 0; c < hold; c++) begin
        tick(mkin(0, 0, 1, 0, 32'd0, 0));
        if (bus.nop_insert) n++;
      end
      for (int c = 0; c < 20; c++) begin
        tick(idle);
        if (bus.state == 3'd1) begin
          reached = 1'b1;
          break;
        end
        if (bus.nop_insert) n++;
      end
      check($sformatf("stall_h%0d.back_to_run", hold), 32'(reached), 32'd1);
      check($sformatf("stall_h%0d.nops", hold), 32'(n), 32'(1 + max_i(STALL_DEPTH, hold)));
      check($sformatf("stall_h%0d.fetch_en", hold), 32'(bus.fetch_en), 32'd1);
    end

    // HALT: drain cycles, then hlt held; start and redirect ignored; rst exits.
    tick(mkin(0, 0, 0, 0, 32'd0, 1));
    n = 0;
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(idle);
      if (bus.hlt) begin
        reached = 1'b1;
        break;
      end
      n++;
    end
    check("halt.reached", 32'(reached), 32'd1);
    check("halt.drain_cycles", 32'(n), 32'(DRAIN_DEPTH));
    check("halt.state", 32'(bus.state), 32'd5);
    tick(mkin(0, 1, 0, 0, 32'd0, 0));
    check("halt.start_ignored", 32'(bus.hlt), 32'd1);
    tick(mkin(0, 0, 1, 1, 32'd7, 1));
    check("halt.redirect_fetch_en", 32'(bus.fetch_en), 32'd0);
    check("halt.redirect_jump", 32'(bus.jump), 32'd0);
    tick(idle);
    check("halt.still_halted", 32'(bus.state), 32'd5);
    check("halt.nop_insert", 32'(bus.nop_insert), 32'd1);
    tick(mkin(1, 0, 0, 0, 32'd0, 0));
    tick(idle);
    check("halt.rst_to_idle", 32'(bus.state), 32'd0);

    // Random stimulus against the behavioural model.
    for (int c = 0; c < 3000; c++) begin
      in_t v;
      v.rst      = ($urandom_range(99) < 2);
      v.start    = ($urandom_range(99) < 30);
      v.hazard   = ($urandom_range(99) < 25);
      v.redirect = ($urandom_range(99) < 10);
      v.halt     = ($urandom_range(99) < 3);
      v.target   = $urandom;
      tick(v);
      compare_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
